// File: rtl/pll_reset_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pll_reset_pkg
//  Description : Shared definitions for the PLL reset sequencer: FSM state
//                encoding (3 bits), default parameter constants and a helper
//                that sizes counters.
//                The PLLRST state only exists when PLL_RESET_SEQ_WATCHDOG_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package pll_reset_pkg;

    localparam int unsigned c_DEF_HOLD_CYCLES    = 1024;
    localparam int unsigned c_DEF_SYNC_STAGES    = 2;
    localparam int unsigned c_DEF_TIMEOUT_CYCLES = 65536;
    localparam int unsigned c_DEF_PLLRST_CYCLES  = 16;
    localparam int unsigned c_DEF_LOSS_W         = 8;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_HOLD      = 3'd1,
        ST_RUN       = 3'd2,
        ST_LOST      = 3'd3
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
        ,
        ST_PLLRST    = 3'd4
`endif
    } state_e;

    // Counter width for a terminal value n: $clog2(n), never below one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : pll_reset_pkg
`default_nettype wire

// File: rtl/sync_ff.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sync_ff
//  Description : Multi-flop synchroniser for a single asynchronous bit.
//                All stages reset to 0. STAGES must be at least 2.
//  Ports       : clk_i  - destination clock
//                rst_ni - asynchronous active-low reset
//                d_i    - asynchronous input bit
//                q_o    - synchronised output (last stage)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : sync_ff
`default_nettype wire

// File: rtl/pll_reset_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pll_reset_seq
//  Description : Holds downstream logic in reset until the PLL has reported
//                lock continuously for HOLD_CYCLES cycles, re-asserts reset on
//                loss of lock and counts lock losses (saturating).
//                Optional watchdog (macro PLL_RESET_SEQ_WATCHDOG_EN): after
//                TIMEOUT_CYCLES without lock, pulses pll_rst_req for
//                PLLRST_CYCLES cycles. Without the macro the sequencer waits
//                for lock indefinitely and pll_rst_req is tied low.
//  Ports       : clock_in    - PLL output clock, sole clock
//                rst_in      - asynchronous active-low reset
//                pll_locked  - raw lock flag, asynchronous
//                rst_out_n   - active-low downstream reset (registered)
//                ready       - high in RUN
//                pll_rst_req - PLL restart request
//                loss_count  - RUN->LOST transitions since reset
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_seq
    import pll_reset_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = c_DEF_HOLD_CYCLES,
    parameter int unsigned SYNC_STAGES    = c_DEF_SYNC_STAGES,
    parameter int unsigned TIMEOUT_CYCLES = c_DEF_TIMEOUT_CYCLES,
    parameter int unsigned PLLRST_CYCLES  = c_DEF_PLLRST_CYCLES,
    parameter int unsigned LOSS_W         = c_DEF_LOSS_W
) (
    input  logic              clock_in,
    input  logic              rst_in,
    input  logic              pll_locked,
    output logic              rst_out_n,
    output logic              ready,
    output logic              pll_rst_req,
    output logic [LOSS_W-1:0] loss_count
);

    localparam int unsigned         c_HOLD_W    = cnt_width(HOLD_CYCLES);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);

    logic                lk;
    state_e              state_q, state_d;
    logic [c_HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [LOSS_W-1:0]   loss_q, loss_d;
    logic                rst_out_q;

`ifdef PLL_RESET_SEQ_WATCHDOG_EN
    localparam int unsigned         c_TMO_W     = cnt_width(TIMEOUT_CYCLES);
    localparam logic [c_TMO_W-1:0]  c_TMO_LAST  = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam int unsigned         c_PRST_W    = cnt_width(PLLRST_CYCLES);
    localparam logic [c_PRST_W-1:0] c_PRST_LAST = c_PRST_W'(PLLRST_CYCLES - 1);

    logic [c_TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [c_PRST_W-1:0] prst_cnt_q, prst_cnt_d;
`else
    // Watchdog parameters have no function in this build.
    logic w_unused_cfg;
    assign w_unused_cfg = ^{TIMEOUT_CYCLES, PLLRST_CYCLES};
`endif

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync_lock (
        .clk_i  (clock_in),
        .rst_ni (rst_in),
        .d_i    (pll_locked),
        .q_o    (lk)
    );

    always_ff @(posedge clock_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ST_WAIT_LOCK;
            hold_cnt_q <= '0;
            loss_q     <= '0;
            rst_out_q  <= 1'b0;
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
            tmo_cnt_q  <= '0;
            prst_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            loss_q     <= loss_d;
            // Registered from the next state so reset release and ready
            // appear on the same edge.
            rst_out_q  <= (state_d == ST_RUN);
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
            tmo_cnt_q  <= tmo_cnt_d;
            prst_cnt_q <= prst_cnt_d;
`endif
        end
    end

    // Counters default to zero, so each one is cleared in every state
    // other than the one it times.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;
        loss_d     = loss_q;
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
        tmo_cnt_d  = '0;
        prst_cnt_d = '0;
`endif
        unique case (state_q)
            ST_WAIT_LOCK: begin
                if (lk) begin
                    state_d = ST_HOLD;
                end
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
                else if (tmo_cnt_q == c_TMO_LAST) begin
                    state_d = ST_PLLRST;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            ST_HOLD: begin
                // Any low cycle abandons the hold; the counter restarts
                // from zero on the next entry.
                if (!lk) begin
                    state_d = ST_WAIT_LOCK;
                end else if (hold_cnt_q == c_HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!lk) begin
                    state_d = ST_LOST;
                    if (loss_q != {LOSS_W{1'b1}}) begin
                        loss_d = loss_q + 1'b1;
                    end
                end
            end
            ST_LOST: begin
                state_d = ST_WAIT_LOCK;
            end
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
            ST_PLLRST: begin
                if (prst_cnt_q == c_PRST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    prst_cnt_d = prst_cnt_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_WAIT_LOCK;
            end
        endcase
    end

    assign rst_out_n  = rst_out_q;
    assign ready      = (state_q == ST_RUN);
    assign loss_count = loss_q;

`ifdef PLL_RESET_SEQ_WATCHDOG_EN
    assign pll_rst_req = (state_q == ST_PLLRST);
`else
    assign pll_rst_req = 1'b0;
`endif

endmodule : pll_reset_seq
`default_nettype wire

// File: tb/tb_pll_reset_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_pll_reset_seq
//  Description : Self-checking bench for pll_reset_seq. A behavioural model
//                tracks the lock history and predicts every output each
//                cycle; directed sequences check release latency, glitch
//                restart, loss saturation, watchdog pulses and async reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reset_seq;

    localparam int unsigned HOLD_CYCLES    = 8;
    localparam int unsigned SYNC_STAGES    = 2;
    localparam int unsigned TIMEOUT_CYCLES = 32;
    localparam int unsigned PLLRST_CYCLES  = 4;
    localparam int unsigned LOSS_W         = 8;
    localparam int unsigned LOSS_MAX       = (1 << LOSS_W) - 1;
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_in;
    logic              pll_locked;
    logic              rst_out_n;
    logic              ready;
    logic              pll_rst_req;
    logic [LOSS_W-1:0] loss_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pll_reset_seq #(
        .HOLD_CYCLES    (HOLD_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .PLLRST_CYCLES  (PLLRST_CYCLES),
        .LOSS_W         (LOSS_W)
    ) dut (
        .clock_in    (clk),
        .rst_in      (rst_in),
        .pll_locked  (pll_locked),
        .rst_out_n   (rst_out_n),
        .ready       (ready),
        .pll_rst_req (pll_rst_req),
        .loss_count  (loss_count)
    );

    // ------------------------------------------------------------------
    // Behavioural model: lock history delayed by SYNC_STAGES edges, then
    // phases described by what the sequencer is doing rather than codes.
    // ------------------------------------------------------------------
    bit m_hist [SYNC_STAGES];
    bit m_run;        // downstream released
    bit m_lost;       // the single cycle after losing lock in run
    int m_hold;       // -1 when not holding, else qualified-lock cycles so far
    int m_starve;     // cycles spent waiting without lock
    int m_kick;       // restart-pulse cycles still to come
    int m_loss;

    task automatic model_reset();
        for (int i = 0; i < SYNC_STAGES; i++) m_hist[i] = 1'b0;
        m_run = 1'b0; m_lost = 1'b0; m_hold = -1;
        m_starve = 0; m_kick = 0; m_loss = 0;
    endtask

    task automatic model_step();
        bit lk_seen;
        lk_seen = m_hist[SYNC_STAGES-1];
        for (int i = SYNC_STAGES - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = pll_locked;

        if (m_kick > 0) begin
            m_kick--;
        end else if (m_lost) begin
            m_lost = 1'b0;
        end else if (m_run) begin
            if (!lk_seen) begin
                m_run  = 1'b0;
                m_lost = 1'b1;
                if (m_loss < LOSS_MAX) m_loss++;
            end
        end else if (m_hold >= 0) begin
            if (!lk_seen) m_hold = -1;
            else if (m_hold == HOLD_CYCLES - 1) begin
                m_run  = 1'b1;
                m_hold = -1;
            end else m_hold++;
        end else begin
            if (lk_seen) begin
                m_hold   = 0;
                m_starve = 0;
            end else if (WD_EN) begin
                if (m_starve == TIMEOUT_CYCLES - 1) begin
                    m_kick   = PLLRST_CYCLES;
                    m_starve = 0;
                end else m_starve++;
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        check_val("rst_out_n",   32'(rst_out_n),   32'(m_run));
        check_val("ready",       32'(ready),       32'(m_run));
        check_val("pll_rst_req", 32'(pll_rst_req), 32'(m_kick > 0));
        check_val("loss_count",  32'(loss_count),  32'(m_loss));
    endtask

    // One clock: drive lock away from the edge, advance the model on the
    // edge, compare on the falling edge.
    task automatic cycle(input bit lock_in);
        pll_locked = lock_in;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic do_reset(input bit lock_during);
        rst_in     = 1'b0;
        pll_locked = lock_during;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("rst_rst_out_n",   32'(rst_out_n),   0);
        check_val("rst_ready",       32'(ready),       0);
        check_val("rst_pll_rst_req", 32'(pll_rst_req), 0);
        check_val("rst_loss_count",  32'(loss_count),  0);
        rst_in = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout: time limit reached, observed running, expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        int rises;
        int first_hi;
        bit prev_req;

        rst_in = 1'b0;
        pll_locked = 1'b0;

        // Release latency from a steady lock; lock is already high while
        // in reset, which must not pre-load the synchroniser.
        do_reset(1'b1);
        n = 0;
        do begin cycle(1'b1); n++; end while (rst_out_n !== 1'b1 && n < 64);
        check_val("release_lat", n, SYNC_STAGES + HOLD_CYCLES + 1);
        check_val("ready_at_release", 32'(ready), 1);

        // One-cycle glitch while the hold count is at 5 restarts the hold.
        do_reset(1'b0);
        repeat (6) cycle(1'b1);
        cycle(1'b0);
        n = 0;
        do begin cycle(1'b1); n++; end while (rst_out_n !== 1'b1 && n < 64);
        check_val("glitch_lat", n, SYNC_STAGES + HOLD_CYCLES + 1);

        // No lock at all: watchdog pulses (or silence without the watchdog).
        do_reset(1'b0);
        rises = 0; first_hi = 0; prev_req = 1'b0;
        for (int i = 1; i <= 3 * (TIMEOUT_CYCLES + PLLRST_CYCLES); i++) begin
            cycle(1'b0);
            if (pll_rst_req === 1'b1 && !prev_req) begin
                rises++;
                if (first_hi == 0) first_hi = i;
            end
            prev_req = (pll_rst_req === 1'b1);
        end
        check_val("wd_rises", rises, WD_EN ? 3 : 0);
        check_val("wd_first", first_hi, WD_EN ? TIMEOUT_CYCLES : 0);

        // Random lock patterns: short glitches, holds, long outages.
        do_reset(1'b0);
        for (int s = 0; s < 60; s++) begin
            bit lvl;
            int len;
            lvl = 1'($urandom_range(0, 1));
            if (lvl) len = $urandom_range(1, 20);
            else if ($urandom_range(0, 3) == 0) len = $urandom_range(30, 80);
            else len = $urandom_range(1, 4);
            repeat (len) cycle(lvl);
        end

        // Repeated lock loss from RUN, driving the counter into saturation.
        do_reset(1'b0);
        for (int k = 0; k < 300; k++) begin
            n = 0;
            do begin cycle(1'b1); n++; end while (rst_out_n !== 1'b1 && n < 64);
            check_val("relock", 32'(rst_out_n), 1);
            n = 0;
            do begin cycle(1'b0); n++; end while (rst_out_n !== 1'b0 && n < 16);
            check_val("drop_lat", n, SYNC_STAGES + 1);
            repeat ($urandom_range(0, 2)) cycle(1'b0);
        end
        check_val("loss_sat", 32'(loss_count), LOSS_MAX);

        // Asynchronous reset from RUN, observed before the next clock edge.
        n = 0;
        do begin cycle(1'b1); n++; end while (ready !== 1'b1 && n < 64);
        check_val("run_before_rst", 32'(ready), 1);
        rst_in = 1'b0;
        #1;
        check_val("async_rst_out_n", 32'(rst_out_n), 0);
        check_val("async_ready",     32'(ready),     0);
        check_val("async_loss",      32'(loss_count), 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_in = 1'b1;
        repeat (4) cycle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pll_reset_seq
`default_nettype wire
